vga_fb_reader: RTL

- Scan-out engine for the 640x480 destination frame buffer that the upscaler/copy engine fills.
- Generates 640x480@60 VGA timing and issues sequential read addresses to the frame buffer's read port.
- Delivers each 8-bit pixel, sync and data-enable to the video output, all cycle-aligned.
- Also reports vertical blanking and frame boundaries, so the control unit can schedule copy-engine runs.

---
 rtl/video_pkg.sv | 38 +++
 rtl/vga_fb_reader_if.sv | 23 ++
 rtl/vga_timing_gen.sv | 73 +++++++
 rtl/vga_fb_reader.sv | 116 +++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared video geometry for the scan-out path and the upscaler.
// Timing constants, frame buffer shape and pipeline flag bundle.
package video_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int FB_WIDTH  = 640;
  localparam int FB_HEIGHT = 480;
  localparam int FB_ADDR_W = 19;
  localparam int FB_PIXELS = FB_WIDTH * FB_HEIGHT;

  localparam int CNT_W = 10;

  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
    logic fs;
  } vid_flags_t;

  localparam vid_flags_t FLAGS_IDLE = '{
    active: 1'b0,
    hs:     1'b1,
    vs:     1'b1,
    fs:     1'b0
  };

endpackage

// File: rtl/vga_fb_reader_if.sv
// Frame buffer read port: address/strobe out, registered data back.
// The RAM side returns data one clock after the address.
interface vga_fb_reader_if #(
  parameter int ADDR_W = 19
);

  logic [ADDR_W-1:0] fb_rd_addr;
  logic              fb_rd_en;
  logic [7:0]        fb_rd_data;

  modport master (
    output fb_rd_addr,
    output fb_rd_en,
    input  fb_rd_data
  );

  modport slave (
    input  fb_rd_addr,
    input  fb_rd_en,
    output fb_rd_data
  );

endinterface

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical raster counters and stage-0 video flags.
// Dropping enable parks both counters at the origin.
module vga_timing_gen #(
  parameter int H_ACTIVE = video_pkg::H_ACTIVE,
  parameter int H_FP     = video_pkg::H_FP,
  parameter int H_SYNC   = video_pkg::H_SYNC,
  parameter int H_BP     = video_pkg::H_BP,
  parameter int V_ACTIVE = video_pkg::V_ACTIVE,
  parameter int V_FP     = video_pkg::V_FP,
  parameter int V_SYNC   = video_pkg::V_SYNC,
  parameter int V_BP     = video_pkg::V_BP
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_enable,
  output logic [video_pkg::CNT_W-1:0] o_h_cnt,
  output logic [video_pkg::CNT_W-1:0] o_v_cnt,
  output logic                       o_active,
  output logic                       o_hs,
  output logic                       o_vs
);

  import video_pkg::*;

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] L_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] L_H_LAST = CNT_W'(HT - 1);
  localparam logic [CNT_W-1:0] L_V_LAST = CNT_W'(VT - 1);
  localparam logic [CNT_W-1:0] L_HA     = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] L_VA     = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] L_HS_B   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] L_HS_E   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] L_VS_B   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] L_VS_E   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [CNT_W-1:0] r_h_cnt;
  logic [CNT_W-1:0] r_v_cnt;
  logic             w_h_wrap;
  logic             w_v_wrap;
  logic             w_in_hs;
  logic             w_in_vs;

  assign w_h_wrap = (r_h_cnt == L_H_LAST);
  assign w_v_wrap = (r_v_cnt == L_V_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (!i_enable) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else begin
      r_h_cnt <= w_h_wrap ? '0 : r_h_cnt + L_ONE;
      if (w_h_wrap) begin
        r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + L_ONE;
      end
    end
  end

  assign w_in_hs = (r_h_cnt >= L_HS_B) && (r_h_cnt <= L_HS_E);
  assign w_in_vs = (r_v_cnt >= L_VS_B) && (r_v_cnt <= L_VS_E);

  // Flags are gated so a disabled scan reads as blank immediately.
  assign o_active = i_enable && (r_h_cnt < L_HA) && (r_v_cnt < L_VA);
  assign o_hs     = !(i_enable && w_in_hs);
  assign o_vs     = !(i_enable && w_in_vs);
  assign o_h_cnt  = r_h_cnt;
  assign o_v_cnt  = r_v_cnt;

endmodule

// File: rtl/vga_fb_reader.sv
// Frame buffer scan-out: raster timing, sequential read addresses
// and a two-stage pipeline aligning RAM data with sync and DE.
module vga_fb_reader #(
  parameter int H_ACTIVE = video_pkg::H_ACTIVE,
  parameter int H_FP     = video_pkg::H_FP,
  parameter int H_SYNC   = video_pkg::H_SYNC,
  parameter int H_BP     = video_pkg::H_BP,
  parameter int V_ACTIVE = video_pkg::V_ACTIVE,
  parameter int V_FP     = video_pkg::V_FP,
  parameter int V_SYNC   = video_pkg::V_SYNC,
  parameter int V_BP     = video_pkg::V_BP,
  parameter int ADDR_W   = video_pkg::FB_ADDR_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  vga_fb_reader_if.master        fb,
  output logic [7:0]             vga_pixel,
  output logic                   vga_hsync,
  output logic                   vga_vsync,
  output logic                   vga_de,
  output logic                   frame_start,
  output logic                   in_vblank
);

  import video_pkg::*;

  localparam int PIXELS = H_ACTIVE * V_ACTIVE;

  localparam logic [ADDR_W-1:0] L_ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] L_ADDR_LAST = ADDR_W'(PIXELS - 1);
  localparam logic [CNT_W-1:0]  L_VA        = CNT_W'(V_ACTIVE);

  logic [CNT_W-1:0]  w_h_cnt;
  logic [CNT_W-1:0]  w_v_cnt;
  logic              w_active;
  logic              w_hs;
  logic              w_vs;
  logic              w_origin;
  logic [ADDR_W-1:0] w_addr_cur;
  vid_flags_t        w_s0;

  logic [ADDR_W-1:0] r_addr_cnt;
  logic [ADDR_W-1:0] r_rd_addr;
  vid_flags_t        r_s1;
  vid_flags_t        r_s2;
  logic              r_vblank;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk      (clk),
    .reset    (reset),
    .i_enable (enable),
    .o_h_cnt  (w_h_cnt),
    .o_v_cnt  (w_v_cnt),
    .o_active (w_active),
    .o_hs     (w_hs),
    .o_vs     (w_vs)
  );

  assign w_origin = (w_h_cnt == '0) && (w_v_cnt == '0);

  // The origin always maps to address 0, so no stale frame state survives.
  assign w_addr_cur = w_origin ? '0 : r_addr_cnt;

  always_comb begin
    w_s0        = FLAGS_IDLE;
    w_s0.active = w_active;
    w_s0.hs     = w_hs;
    w_s0.vs     = w_vs;
    w_s0.fs     = w_origin && enable;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr_cnt <= '0;
      r_rd_addr  <= '0;
      r_s1       <= FLAGS_IDLE;
      r_s2       <= FLAGS_IDLE;
      r_vblank   <= 1'b0;
    end else begin
      r_rd_addr <= w_addr_cur;
      r_s1      <= w_s0;
      r_s2      <= r_s1;
      r_vblank  <= (w_v_cnt >= L_VA);
      if (!enable) begin
        r_addr_cnt <= '0;
      end else if (w_active) begin
        r_addr_cnt <= (w_addr_cur == L_ADDR_LAST) ? '0
                    : w_addr_cur + L_ADDR_ONE;
      end else begin
        r_addr_cnt <= w_addr_cur;
      end
    end
  end

  assign fb.fb_rd_addr = r_rd_addr;
  assign fb.fb_rd_en   = r_s1.active;

  // RAM data lands in the same cycle as the stage-2 flags.
  assign vga_pixel   = r_s2.active ? fb.fb_rd_data : 8'd0;
  assign vga_de      = r_s2.active;
  assign vga_hsync   = r_s2.hs;
  assign vga_vsync   = r_s2.vs;
  assign frame_start = r_s2.fs;
  assign in_vblank   = r_vblank;

endmodule
